// File: rtl/steer_buffer.sv
// steer_buffer: ping-pong pair of 8x8 banks with sequential or steered reads
module steer_buffer (
   input  logic       clk,
   input  logic       resetn,
   input  logic [7:0] datain,
   input  logic       enwr,
   input  logic       enrd,
   input  logic       wa,
   input  logic       ena,
   input  logic       enb,
   input  logic       resetaddr,
   input  logic       ensteer,
   input  logic [2:0] selectline,
   output logic [7:0] dataout,
   output logic       dataval,
   output logic [1:0] statea,
   output logic [1:0] stateb,
   output logic [2:0] ptra,
   output logic [2:0] ptrb,
   output logic       bankdone,
   output logic       overrun
);
   typedef enum logic [1:0] {EMPTY, FILL, FULL, DRAIN} state_t;
   state_t     st  [2];
   logic [2:0] ptr [2];
   logic [7:0] mem [2][8];
   logic wb, rb, wr_hit, rd_hit, wr_ok, wr_blk, seq_ok, str_ok;
   // bank index 0 is A, 1 is B; the read bank is always the one not being written
   assign wb     = wa;
   assign rb     = ~wa;
   assign wr_hit = enwr && (wa ? enb : ena);
   assign rd_hit = enrd && (wa ? ena : enb);
   assign wr_ok  = wr_hit && (st[wb] == EMPTY || st[wb] == FILL);
   assign wr_blk = wr_hit && !wr_ok;
   assign seq_ok = rd_hit && !ensteer && (st[rb] == FULL || st[rb] == DRAIN);
   assign str_ok = rd_hit && ensteer;
   assign statea = st[0];
   assign stateb = st[1];
   assign ptra   = ptr[0];
   assign ptrb   = ptr[1];
   always_ff @(posedge clk)
      if (resetn && !resetaddr && wr_ok) mem[wb][ptr[wb]] <= datain;
   always_ff @(posedge clk) begin
      if (!resetn) begin
         st[0]    <= EMPTY;
         st[1]    <= EMPTY;
         ptr[0]   <= '0;
         ptr[1]   <= '0;
         dataout  <= '0;
         dataval  <= 1'b0;
         bankdone <= 1'b0;
         overrun  <= 1'b0;
      end else if (resetaddr) begin
         st[0]    <= EMPTY;
         st[1]    <= EMPTY;
         ptr[0]   <= '0;
         ptr[1]   <= '0;
         dataval  <= 1'b0;
         bankdone <= 1'b0;
      end else begin
         dataval  <= seq_ok || str_ok;
         bankdone <= seq_ok && ptr[rb] == 3'd7;
         if (wr_blk) overrun <= 1'b1;
         if (wr_ok) begin
            ptr[wb] <= ptr[wb] + 3'd1;
            st[wb]  <= ptr[wb] == 3'd7 ? FULL : FILL;
         end
         if (seq_ok) begin
            ptr[rb] <= ptr[rb] + 3'd1;
            st[rb]  <= ptr[rb] == 3'd7 ? EMPTY : DRAIN;
            dataout <= mem[rb][ptr[rb]];
         end else if (str_ok) begin
            dataout <= mem[rb][selectline];
         end
      end
   end
endmodule

// File: tb/tb_steer_buffer.sv
// tb_steer_buffer: directed stimulus with a read-data scoreboard and state checks
module tb_steer_buffer;
   logic       clk = 1'b0, resetn = 1'b0, enwr = 1'b0, enrd = 1'b0, wa = 1'b0;
   logic       ena = 1'b0, enb = 1'b0, resetaddr = 1'b0, ensteer = 1'b0;
   logic [7:0] datain = '0;
   logic [2:0] selectline = '0;
   logic [7:0] dataout;
   logic       dataval, bankdone, overrun;
   logic [1:0] statea, stateb;
   logic [2:0] ptra, ptrb;
   logic [8:0] exp_q [$];
   logic [8:0] e;
   int passed = 0, total = 0;

   steer_buffer dut (
      .clk(clk), .resetn(resetn), .datain(datain), .enwr(enwr), .enrd(enrd),
      .wa(wa), .ena(ena), .enb(enb), .resetaddr(resetaddr), .ensteer(ensteer),
      .selectline(selectline), .dataout(dataout), .dataval(dataval),
      .statea(statea), .stateb(stateb), .ptra(ptra), .ptrb(ptrb),
      .bankdone(bankdone), .overrun(overrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s got=%0h expected=%0h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // each expected read is {bankdone, dataout}, consumed when the DUT flags a read
   always @(negedge clk)
      if (dataval || bankdone) begin
         if (exp_q.size() == 0) begin
            total++;
            $display("FAIL unexpected_read got dataval=%0b bankdone=%0b dataout=%0h expected none",
                     dataval, bankdone, dataout);
         end else begin
            e = exp_q.pop_front();
            chk("rd_valid", dataval, 1);
            chk("rd_data", dataout, e[7:0]);
            chk("rd_done", bankdone, e[8]);
         end
      end

   initial begin
      step();
      step();
      chk("rst_dataout", dataout, 0);
      chk("rst_dataval", dataval, 0);
      chk("rst_statea", statea, 0);
      chk("rst_stateb", stateb, 0);
      chk("rst_ptra", ptra, 0);
      chk("rst_ptrb", ptrb, 0);
      chk("rst_bankdone", bankdone, 0);
      chk("rst_overrun", overrun, 0);
      resetn = 1'b1;
      ena = 1'b1;
      enb = 1'b1;
      // fill A with 0x10..0x17
      wa = 1'b0;
      enwr = 1'b1;
      for (int i = 0; i < 8; i++) begin
         datain = 8'h10 + 8'(i);
         step();
         chk("fill_statea", statea, i < 7 ? 1 : 2);
      end
      enwr = 1'b0;
      chk("fill_ptra", ptra, 0);
      chk("fill_overrun", overrun, 0);
      // steered read of a FULL bank leaves it untouched
      wa = 1'b1;
      ensteer = 1'b1;
      selectline = 3'd5;
      enrd = 1'b1;
      exp_q.push_back({1'b0, 8'h15});
      step();
      enrd = 1'b0;
      ensteer = 1'b0;
      chk("steer_ptra", ptra, 0);
      chk("steer_statea", statea, 2);
      // write into FULL bank is suppressed and flags overrun
      wa = 1'b0;
      enwr = 1'b1;
      datain = 8'hAA;
      step();
      enwr = 1'b0;
      chk("ovr_flag", overrun, 1);
      chk("ovr_statea", statea, 2);
      chk("ovr_ptra", ptra, 0);
      // drain A sequentially
      wa = 1'b1;
      enrd = 1'b1;
      for (int i = 0; i < 8; i++) begin
         exp_q.push_back({i == 7, 8'h10 + 8'(i)});
         step();
         chk("drain_statea", statea, i < 7 ? 3 : 0);
      end
      enrd = 1'b0;
      step();
      chk("idle_dataval", dataval, 0);
      chk("idle_bankdone", bankdone, 0);
      chk("ovr_sticky", overrun, 1);
      // sequential read of an EMPTY bank is suppressed
      enrd = 1'b1;
      step();
      enrd = 1'b0;
      chk("empty_rd_dataval", dataval, 0);
      // refill A, then write B while draining A
      wa = 1'b0;
      enwr = 1'b1;
      for (int i = 0; i < 8; i++) begin
         datain = 8'h20 + 8'(i);
         step();
      end
      chk("refill_statea", statea, 2);
      wa = 1'b1;
      enrd = 1'b1;
      for (int i = 0; i < 8; i++) begin
         datain = 8'h30 + 8'(i);
         exp_q.push_back({i == 7, 8'h20 + 8'(i)});
         step();
         chk("pp_stateb", stateb, i < 7 ? 1 : 2);
         chk("pp_statea", statea, i < 7 ? 3 : 0);
      end
      // swap roles: write A while draining B
      wa = 1'b0;
      for (int i = 0; i < 8; i++) begin
         datain = 8'h40 + 8'(i);
         exp_q.push_back({i == 7, 8'h30 + 8'(i)});
         step();
         chk("pp2_statea", statea, i < 7 ? 1 : 2);
         chk("pp2_stateb", stateb, i < 7 ? 3 : 0);
      end
      enwr = 1'b0;
      // partial drain of A then resetaddr
      wa = 1'b1;
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back({1'b0, 8'h40 + 8'(i)});
         step();
      end
      chk("part_ptra", ptra, 3);
      chk("part_statea", statea, 3);
      resetaddr = 1'b1;
      enwr = 1'b1;
      step();
      resetaddr = 1'b0;
      enwr = 1'b0;
      chk("ra_statea", statea, 0);
      chk("ra_ptra", ptra, 0);
      chk("ra_stateb", stateb, 0);
      chk("ra_ptrb", ptrb, 0);
      chk("ra_dataval", dataval, 0);
      chk("ra_dataout_hold", dataout, 8'h42);
      chk("ra_overrun_hold", overrun, 1);
      step();
      enrd = 1'b0;
      chk("ra_rd_dataval", dataval, 0);
      // steered read works in EMPTY; contents survive resetaddr
      ensteer = 1'b1;
      selectline = 3'd2;
      enrd = 1'b1;
      exp_q.push_back({1'b0, 8'h42});
      step();
      // disabled bank ignores reads and writes
      ena = 1'b0;
      step();
      enrd = 1'b0;
      ensteer = 1'b0;
      chk("dis_rd_dataval", dataval, 0);
      wa = 1'b0;
      enwr = 1'b1;
      step();
      chk("dis_wr_statea", statea, 0);
      chk("dis_wr_ptra", ptra, 0);
      // reset mid-fill aborts; first write after release is accepted
      ena = 1'b1;
      step();
      step();
      chk("mid_ptra", ptra, 2);
      chk("mid_statea", statea, 1);
      resetn = 1'b0;
      step();
      chk("mid_rst_statea", statea, 0);
      chk("mid_rst_ptra", ptra, 0);
      chk("mid_rst_overrun", overrun, 0);
      chk("mid_rst_dataout", dataout, 0);
      resetn = 1'b1;
      datain = 8'h55;
      step();
      enwr = 1'b0;
      chk("post_rst_ptra", ptra, 1);
      chk("post_rst_statea", statea, 1);
      step();
      step();
      chk("scoreboard_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/steer_buffer.md
STEER_BUFFER -- requirements
Module: steer_buffer

Interface
REQ-001 clk  input  1  single clock, all state updates on rising edge.
REQ-002 resetn  input  1  reset; synchronous and active-low, sampled on rising clk.
REQ-003 datain  input  8  write data from upstream source.
REQ-004 enwr  input  1  write request, from CM.
REQ-005 enrd  input  1  read request, from CM.
REQ-006 wa  input  1  write-bank select from CM: 0 = write bank A / read bank B; 1 = write bank B / read bank A.
REQ-007 ena, enb  input  1 each  bank enables from CM; a bank not enabled ignores every access.
REQ-008 resetaddr  input  1  address/state clear from CM.
REQ-009 ensteer  input  1  steered (random-access) read mode from CM.
REQ-010 selectline  input  3  word index used for steered reads.
REQ-011 dataout  output  8  registered read data.
REQ-012 dataval  output  1  dataout valid, one-cycle pulse per read.
REQ-013 statea, stateb  output  2 each  bank FSM state: 0 EMPTY, 1 FILL, 2 FULL, 3 DRAIN.
REQ-014 ptra, ptrb  output  3 each  bank word pointers.
REQ-015 bankdone  output  1  one-cycle pulse when any bank returns DRAIN -> EMPTY.
REQ-016 overrun  output  1  sticky error flag.

Function
REQ-017 Storage: two banks (A, B), each 8 words x 8 bits; contents not reset.
REQ-018 Write bank = wa ? B : A; read bank = the other bank; wa is resampled every cycle.
REQ-019 Write accepted when enwr=1, the write bank is enabled, and its state is EMPTY or FILL: store datain at bank[ptr], ptr+1 mod 8.
REQ-020 Write-bank FSM: EMPTY -> FILL on the first accepted write; FILL -> FULL on the write at ptr=7 (ptr wraps to 0).
REQ-021 Write with enwr=1 to an enabled write bank in FULL or DRAIN: suppressed, no state or pointer change, overrun set to 1.
REQ-022 Sequential read accepted when enrd=1, ensteer=0, the read bank is enabled, and its state is FULL or DRAIN: dataout <= bank[ptr] on the next edge, dataval=1, ptr+1 mod 8.
REQ-023 Read-bank FSM: FULL -> DRAIN on the first accepted read; DRAIN -> EMPTY on the read at ptr=7 (ptr wraps to 0); bankdone=1 in the same cycle dataval is asserted for that read.
REQ-024 Sequential read when the read bank is EMPTY or FILL: suppressed, dataval=0, dataout holds.
REQ-025 Steered read when enrd=1, ensteer=1, and the read bank is enabled: dataout <= read bank[selectline], dataval=1, in any state; no pointer or state change.
REQ-026 Read latency is 1 cycle (request edge -> dataval high); writes are visible to reads from the next cycle onward.
REQ-027 A write and a read in the same cycle target different banks and both proceed independently.
REQ-028 resetaddr=1: both ptrs cleared to 0, both banks forced to EMPTY, dataval=0; concurrent enwr/enrd ignored; overrun and dataout held.
REQ-029 Priority: resetn > resetaddr > enwr/enrd.
REQ-030 dataval and bankdone are 0 in every cycle without an accepted read.

Reset
REQ-031 When resetn=0 at a rising edge: dataout=0, dataval=0, statea=stateb=0, ptra=ptrb=0, bankdone=0, overrun=0.
REQ-032 Reset asserted mid-fill or mid-drain aborts the operation and is fully effective after one edge; the first access is accepted on the first edge with resetn=1.

Verification
REQ-033 Reset, then wa=0, ena=1, enwr=1 with datain 0x10..0x17 over 8 cycles -> statea goes 1 after the 1st write and 2 after the 8th; ptra=0; overrun=0.
REQ-034 Continue with wa=1, enb=1, enrd=1 for 8 cycles -> dataout 0x10..0x17 each one cycle after its request, dataval=1 throughout, statea 3 then 0, bankdone pulses with 0x17.
REQ-035 Bank A FULL, wa=0, enwr=1 -> write suppressed, overrun=1 and stays 1 until resetn=0.
REQ-036 Bank A FULL, wa=1, ensteer=1, selectline=5, enrd=1 -> dataout=0x15, dataval=1, ptra=0, statea=2 unchanged.
REQ-037 Simultaneous write to B (wa=1) and sequential read from A over 8 cycles -> B reaches FULL, A reaches EMPTY in the same cycle, bankdone=1 once.
REQ-038 resetaddr=1 with A in DRAIN at ptr=3 -> next cycle statea=0, ptra=0, dataval=0; enrd on A then yields dataval=0.
